vec_mem_master: RTL and testbench
=================================

# vec_mem_master

Initiator side of the scalar/vector data-memory port. Accepts one strided vector load or store request of up to `VLEN_ELEMS` 64-bit elements. It issues one memory access per cycle on the `memread_mem`/`memwrite_mem`/addr/wd/rd port, gathers load data into an element buffer, and returns a single completion pulse. It sits between the vector execute stage and the 64-bit word-addressed data memory. That memory returns read data combinationally in the same cycle and commits writes on the rising clock edge.

## Interface
- `VLEN_ELEMS`, 8: maximum elements per request; fixes buffer depth and `req_vl` clamp.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high in IDLE only.
- `req_store` in 1: 1 = store, 0 = load.
- `req_base` in 64: byte address of element 0.
- `req_stride` in 64: signed byte stride between elements.
- `req_vl` in 4: element count; values above `VLEN_ELEMS` are clamped.
- `req_wdata` in 64*VLEN_ELEMS: store data; element i at [64i+63:64i].
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_err` out 1: valid with `resp_valid`; misalignment flag.
- `resp_rdata` out 64*VLEN_ELEMS: load result, same packing as `req_wdata`.
- `memread_mem` out 1: read strobe to data memory.
- `memwrite_mem` out 1: write strobe to data memory.
- `mem_addr` out 64: byte address to data memory.
- `mem_wd` out 64: write data to data memory.
- `mem_rd` in 64: read data from data memory; combinational, same cycle as address.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE
  - `req_ready`=1.
  - On `req_valid`: latch store flag, base, stride, clamped vl and wdata; set idx=0 and cur_addr=base.
  - For loads, clear the element buffer to 0.
- Transition out of IDLE on accept:
  - To DONE with err=1 if `req_base[2:0]`≠0 or `req_stride[2:0]`≠0.
  - Otherwise to DONE with err=0 if vl=0.
  - Otherwise to ACCESS.
- ACCESS, each cycle:
  - `mem_addr`=cur_addr.
  - Load: `memread_mem`=1 and capture `mem_rd` into buffer[idx] at the clock edge.
  - Store: `memwrite_mem`=1 and `mem_wd`=wdata element idx.
  - At the edge: cur_addr += stride (modulo 2^64) and idx++.
  - When idx = vl-1, go to DONE.
- DONE
  - `resp_valid`=1 for exactly one cycle, then return to IDLE.
  - For loads, `resp_rdata` is updated from the buffer on entry to DONE.
  - Elements at index ≥ vl read 0.
- `resp_rdata` changes only on load completion and holds between responses.
  - A store leaves it unchanged.
  - An erroring or vl=0 load drives it to all zeros.
- `req_valid` is ignored outside IDLE; there is no queueing.
- `memread_mem` and `memwrite_mem` are never both 1.
- Both strobes are 0 outside ACCESS.
- `mem_addr` and `mem_wd` are 0 outside ACCESS.

## Timing
- Reset values:
  - state IDLE, `req_ready`=1.
  - `resp_valid`=0, `resp_err`=0, `resp_rdata`=0.
  - `memread_mem`=0, `memwrite_mem`=0, `mem_addr`=0, `mem_wd`=0.
  - idx=0, buffer=0.
- No request is accepted while `rst_n`=0.
- Latency, with the request accepted at edge t:
  - Access k (0-based) is driven in cycle t+1+k.
  - `resp_valid` is high in cycle t+1+vl.
  - The next request can be accepted at the edge closing cycle t+2+vl.
- vl=0 or misaligned: `resp_valid` in cycle t+1; zero memory strobes.
- Reset mid-operation: strobes drop to 0 immediately (asynchronous) and state returns to IDLE.
  - Store elements already committed remain in memory; no further writes occur.
  - No `resp_valid` is produced for the aborted request.
- Address wrap past 2^64-1 or below 0 is not an error; the address wraps silently.

## Test plan
- Unit-stride load:
  - Stimulus: memory words at 0x100, 0x108, 0x110, 0x118 preloaded with 0xA0, 0xA1, 0xA2, 0xA3; request base=0x100, stride=8, vl=4.
  - Response: `memread_mem` for 4 cycles at those addresses; `resp_valid` in cycle 5 after accept; `resp_rdata` elements 0–3 = A0–A3, elements 4–7 = 0; `resp_err`=0.
- Strided store, then load-back:
  - Stimulus: store base=0x200, stride=16, vl=3, data 0x11/0x22/0x33; then load with the same base, stride and vl.
  - Response: `memwrite_mem` for 3 cycles at 0x200, 0x210, 0x220; the load returns 0x11, 0x22, 0x33.
- Negative stride and clamp:
  - Stimulus: load base=0x40, stride=-8, vl=12.
  - Response: exactly 8 accesses at 0x40 down to 0x08; `resp_valid` 9 cycles after accept.
- vl=0 and misalignment:
  - Stimulus A: load with vl=0.
  - Response A: no strobes; `resp_valid`=1 and `resp_err`=0 in cycle 1; `resp_rdata`=0.
  - Stimulus B: base=0x104.
  - Response B: no strobes; `resp_err`=1.
- Reset mid-store:
  - Stimulus: store vl=6 to 0x300, stride=8; assert `rst_n`=0 after 2 accesses.
  - Response: strobes drop in the same cycle; only 0x300 and 0x308 are written; no `resp_valid`; `req_ready`=1 after release.
- Busy rejection:
  - Stimulus: hold `req_valid`=1 during ACCESS with a different base.
  - Response: the second request is not accepted until after DONE; the in-flight address sequence is undisturbed.

Source files
------------

// File: rtl/vec_mem_master_if.sv
// Request, response and data-memory bundle between the vector execute stage,
// the vec_mem_master initiator and the 64-bit word-addressed data memory.
interface vec_mem_master_if #(
  parameter int VLEN_ELEMS = 8
);

  // Request side (execute stage -> master)
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_store;
  logic [63:0]               req_base;
  logic [63:0]               req_stride;
  logic [3:0]                req_vl;
  logic [64*VLEN_ELEMS-1:0]  req_wdata;

  // Response side (master -> execute stage)
  logic                      resp_valid;
  logic                      resp_err;
  logic [64*VLEN_ELEMS-1:0]  resp_rdata;

  // Data-memory port (master -> memory, read data returns combinationally)
  logic                      memread_mem;
  logic                      memwrite_mem;
  logic [63:0]               mem_addr;
  logic [63:0]               mem_wd;
  logic [63:0]               mem_rd;

  // View of the vector memory master itself
  modport master (
    input  req_valid, req_store, req_base, req_stride, req_vl, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_err, resp_rdata,
           memread_mem, memwrite_mem, mem_addr, mem_wd
  );

  // View of the environment around the master (requester plus memory)
  modport slave (
    output req_valid, req_store, req_base, req_stride, req_vl, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           memread_mem, memwrite_mem, mem_addr, mem_wd
  );

endinterface

// File: rtl/vec_mem_master.sv
// vec_mem_master: executes one strided vector load/store of up to VLEN_ELEMS
// 64-bit elements as one memory access per cycle, gathers load data into an
// element buffer and reports completion with a single-cycle response pulse.
// All outputs toward the memory and the requester come straight from flops so
// the memory strobes fall asynchronously with rst_n.
module vec_mem_master #(
  parameter int VLEN_ELEMS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  vec_mem_master_if.master bus
);

  localparam int         IW     = (VLEN_ELEMS > 1) ? $clog2(VLEN_ELEMS) : 1;
  localparam int         DW     = 64 * VLEN_ELEMS;
  localparam logic [3:0] VL_MAX = 4'(VLEN_ELEMS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // A request is misaligned when either its base or its stride is not a
  // multiple of the 8-byte word size.
  function automatic logic is_misaligned(input logic [2:0] base_lsb,
                                         input logic [2:0] stride_lsb);
    return (base_lsb != 3'b000) || (stride_lsb != 3'b000);
  endfunction

  // Requested element counts above the buffer depth are clamped to it.
  function automatic logic [3:0] clamp_vl(input logic [3:0] vl);
    return (vl > VL_MAX) ? VL_MAX : vl;
  endfunction

  // Control state and latched request context
  state_t          state_r;
  state_t          state_nxt_s;
  logic            store_r;
  logic [63:0]     stride_r;
  logic [63:0]     cur_addr_r;
  logic [3:0]      vl_r;
  logic [IW-1:0]   idx_r;
  logic [IW-1:0]   idx_inc_s;
  logic [63:0]     wdata_r [VLEN_ELEMS];
  logic [63:0]     buf_r   [VLEN_ELEMS];

  // Registered outputs
  logic            ready_r;
  logic            resp_valid_r;
  logic            resp_err_r;
  logic [DW-1:0]   resp_rdata_r;
  logic            mem_read_r;
  logic            mem_write_r;
  logic [63:0]     mem_addr_r;
  logic [63:0]     mem_wd_r;

  // Next-cycle values
  logic            accept_s;
  logic            last_s;
  logic            req_misaligned_s;
  logic [3:0]      req_vl_s;
  logic            err_nxt_s;
  logic            mem_read_nxt_s;
  logic            mem_write_nxt_s;
  logic [63:0]     mem_addr_nxt_s;
  logic [63:0]     mem_wd_nxt_s;
  logic [DW-1:0]   rdata_nxt_s;

  assign req_misaligned_s = is_misaligned(bus.req_base[2:0], bus.req_stride[2:0]);
  assign req_vl_s         = clamp_vl(bus.req_vl);
  assign idx_inc_s        = idx_r + IW'(1);

  // Next-state decode plus the memory-port values for the following cycle.
  always_comb begin
    state_nxt_s     = state_r;
    accept_s        = 1'b0;
    last_s          = 1'b0;
    err_nxt_s       = 1'b0;
    mem_read_nxt_s  = 1'b0;
    mem_write_nxt_s = 1'b0;
    mem_addr_nxt_s  = 64'd0;
    mem_wd_nxt_s    = 64'd0;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid) begin
          accept_s = 1'b1;
          if (req_misaligned_s) begin
            state_nxt_s = ST_DONE;
            err_nxt_s   = 1'b1;
          end else if (req_vl_s == 4'd0) begin
            state_nxt_s = ST_DONE;
          end else begin
            // First access goes out in the cycle right after acceptance.
            state_nxt_s     = ST_ACCESS;
            mem_read_nxt_s  = ~bus.req_store;
            mem_write_nxt_s = bus.req_store;
            mem_addr_nxt_s  = bus.req_base;
            mem_wd_nxt_s    = bus.req_store ? bus.req_wdata[63:0] : 64'd0;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (4'(idx_r) == (vl_r - 4'd1)) begin
          state_nxt_s = ST_DONE;
          last_s      = 1'b1;
        end else begin
          // Address arithmetic wraps modulo 2^64 by construction.
          state_nxt_s     = ST_ACCESS;
          mem_read_nxt_s  = ~store_r;
          mem_write_nxt_s = store_r;
          mem_addr_nxt_s  = cur_addr_r + stride_r;
          mem_wd_nxt_s    = store_r ? wdata_r[idx_inc_s] : 64'd0;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Load result: zero for rejected/empty loads, otherwise the buffer with the
  // final element taken directly from the memory in the last access cycle.
  always_comb begin
    rdata_nxt_s = resp_rdata_r;
    if (accept_s && !bus.req_store && (state_nxt_s == ST_DONE)) begin
      rdata_nxt_s = {DW{1'b0}};
    end else if (last_s && !store_r) begin
      for (int i = 0; i < VLEN_ELEMS; i++) begin
        if (IW'(i) == idx_r) begin
          rdata_nxt_s[64*i +: 64] = bus.mem_rd;
        end else begin
          rdata_nxt_s[64*i +: 64] = buf_r[i];
        end
      end
    end else begin
      rdata_nxt_s = resp_rdata_r;
    end
  end

  // State register and registered handshake/memory-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      ready_r      <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_addr_r   <= 64'd0;
      mem_wd_r     <= 64'd0;
    end else begin
      state_r      <= state_nxt_s;
      ready_r      <= (state_nxt_s == ST_IDLE);
      resp_valid_r <= (state_nxt_s == ST_DONE);
      resp_err_r   <= err_nxt_s;
      mem_read_r   <= mem_read_nxt_s;
      mem_write_r  <= mem_write_nxt_s;
      mem_addr_r   <= mem_addr_nxt_s;
      mem_wd_r     <= mem_wd_nxt_s;
    end
  end

  // Latch the request context on acceptance; walk address and index per access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_r    <= 1'b0;
      stride_r   <= 64'd0;
      cur_addr_r <= 64'd0;
      vl_r       <= 4'd0;
      idx_r      <= {IW{1'b0}};
      for (int i = 0; i < VLEN_ELEMS; i++) begin
        wdata_r[i] <= 64'd0;
      end
    end else if (accept_s) begin
      store_r    <= bus.req_store;
      stride_r   <= bus.req_stride;
      cur_addr_r <= bus.req_base;
      vl_r       <= req_vl_s;
      idx_r      <= {IW{1'b0}};
      for (int i = 0; i < VLEN_ELEMS; i++) begin
        wdata_r[i] <= bus.req_wdata[64*i +: 64];
      end
    end else if (state_r == ST_ACCESS) begin
      cur_addr_r <= cur_addr_r + stride_r;
      idx_r      <= idx_inc_s;
    end
  end

  // Element buffer: cleared when a load is accepted, filled one word per access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < VLEN_ELEMS; i++) begin
        buf_r[i] <= 64'd0;
      end
    end else if (accept_s && !bus.req_store) begin
      for (int i = 0; i < VLEN_ELEMS; i++) begin
        buf_r[i] <= 64'd0;
      end
    end else if ((state_r == ST_ACCESS) && !store_r) begin
      buf_r[idx_r] <= bus.mem_rd;
    end
  end

  // Response data holds between load completions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata_r <= {DW{1'b0}};
    end else begin
      resp_rdata_r <= rdata_nxt_s;
    end
  end

  assign bus.req_ready    = ready_r;
  assign bus.resp_valid   = resp_valid_r;
  assign bus.resp_err     = resp_err_r;
  assign bus.resp_rdata   = resp_rdata_r;
  assign bus.memread_mem  = mem_read_r;
  assign bus.memwrite_mem = mem_write_r;
  assign bus.mem_addr     = mem_addr_r;
  assign bus.mem_wd       = mem_wd_r;

endmodule

// File: tb/tb_vec_mem_master.sv
// Scoreboard bench for vec_mem_master: the stimulus thread queues expected
// memory accesses and responses (with their cycle numbers); a negedge monitor
// pops and compares whenever the DUT strobes memory or pulses resp_valid.
module tb_vec_mem_master;

  localparam int V = 8;
  localparam int W = 64 * V;
  localparam logic [63:0] C = 64'hC0DE_0000_0000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  vec_mem_master_if #(.VLEN_ELEMS(V)) bus ();

  vec_mem_master #(.VLEN_ELEMS(V)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Word-addressed data memory: combinational read, write on rising edge.
  logic [63:0] mem [0:255];
  assign bus.mem_rd = bus.memread_mem ? mem[bus.mem_addr[10:3]] : 64'd0;
  always @(posedge clk) begin
    if (bus.memwrite_mem) mem[bus.mem_addr[10:3]] = bus.mem_wd;
  end

  typedef struct { logic we; logic [63:0] addr; logic [63:0] wd; int cyc; } acc_t;
  typedef struct { logic err; logic [W-1:0] rdata; int cyc; } rsp_t;
  acc_t acc_q[$];
  rsp_t rsp_q[$];

  function automatic void chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endfunction

  function automatic void fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endfunction

  function automatic logic [W-1:0] pk(input logic [63:0] e0, e1, e2, e3, e4, e5, e6, e7);
    return {e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  // Monitor: compares every memory access and every response against the queues.
  always @(negedge clk) begin
    acc_t a;
    rsp_t r;
    if (rst_n) begin
      chk("strobe_excl", W'(bus.memread_mem & bus.memwrite_mem), '0);
      if (bus.memread_mem || bus.memwrite_mem) begin
        if (acc_q.size() == 0) begin
          fail_now("unexpected_access");
        end else begin
          a = acc_q.pop_front();
          chk("acc_we",    W'(bus.memwrite_mem), W'(a.we));
          chk("acc_addr",  W'(bus.mem_addr), W'(a.addr));
          chk("acc_cycle", W'(cyc), W'(a.cyc));
          if (a.we) chk("acc_wd", W'(bus.mem_wd), W'(a.wd));
        end
      end else begin
        chk("idle_bus", W'({bus.mem_addr, bus.mem_wd}), '0);
      end
      if (bus.resp_valid) begin
        if (rsp_q.size() == 0) begin
          fail_now("unexpected_resp");
        end else begin
          r = rsp_q.pop_front();
          chk("resp_err",   W'(bus.resp_err), W'(r.err));
          chk("resp_rdata", bus.resp_rdata, r.rdata);
          chk("resp_cycle", W'(cyc), W'(r.cyc));
        end
      end
    end
  end

  // Present a request (called at a negedge), wait for acceptance and queue expectations.
  task automatic issue(input logic st, input logic [63:0] base, input logic [63:0] stride,
                       input logic [3:0] vl, input logic [W-1:0] wdata, input int n_acc,
                       input logic exp_err, input logic [W-1:0] exp_rdata,
                       input logic exp_resp, input logic keep_valid, output int acc_cyc);
    int   n;
    acc_t a;
    rsp_t r;
    bus.req_store  = st;
    bus.req_base   = base;
    bus.req_stride = stride;
    bus.req_vl     = vl;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      fail_now("accept_timeout");
      bus.req_valid = 1'b0;
      acc_cyc = -1;
    end else begin
      acc_cyc = cyc;
      for (int k = 0; k < n_acc; k++) begin
        a.we   = st;
        a.addr = base + 64'(k) * stride;
        a.wd   = wdata[64*k +: 64];
        a.cyc  = acc_cyc + 1 + k;
        acc_q.push_back(a);
      end
      if (exp_resp) begin
        r.err   = exp_err;
        r.rdata = exp_rdata;
        r.cyc   = acc_cyc + 1 + n_acc;
        rsp_q.push_back(r);
      end
      @(negedge clk);
      if (!keep_valid) bus.req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((acc_q.size() != 0 || rsp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_acc", W'(acc_q.size()), '0);
    chk("drain_rsp", W'(rsp_q.size()), '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1;
    int c2;
    logic [W-1:0] ld_a;
    for (int i = 0; i < 256; i++) mem[i] = C | 64'(i);
    mem[32] = 64'hA0;
    mem[33] = 64'hA1;
    mem[34] = 64'hA2;
    mem[35] = 64'hA3;
    ld_a = pk(64'hA0, 64'hA1, 64'hA2, 64'hA3, 64'd0, 64'd0, 64'd0, 64'd0);
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_base   = 64'd0;
    bus.req_stride = 64'd0;
    bus.req_vl     = 4'd0;
    bus.req_wdata  = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ready",      W'(bus.req_ready), W'(1'b1));
    chk("rst_resp_valid", W'(bus.resp_valid), '0);
    chk("rst_resp_err",   W'(bus.resp_err), '0);
    chk("rst_rdata",      bus.resp_rdata, '0);
    chk("rst_strobes",    W'({bus.memread_mem, bus.memwrite_mem}), '0);
    chk("rst_addr_wd",    W'({bus.mem_addr, bus.mem_wd}), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Unit-stride load
    issue(1'b0, 64'h100, 64'd8, 4'd4, '0, 4, 1'b0, ld_a, 1'b1, 1'b0, c1);
    // Strided store (rdata must hold), then load-back
    issue(1'b1, 64'h200, 64'd16, 4'd3,
          pk(64'h11, 64'h22, 64'h33, 64'hEEEE_EEEE_EEEE_EEE3, 64'hEEEE_EEEE_EEEE_EEE4,
             64'hEEEE_EEEE_EEEE_EEE5, 64'hEEEE_EEEE_EEEE_EEE6, 64'hEEEE_EEEE_EEEE_EEE7),
          3, 1'b0, ld_a, 1'b1, 1'b0, c1);
    issue(1'b0, 64'h200, 64'd16, 4'd3, '0, 3, 1'b0,
          pk(64'h11, 64'h22, 64'h33, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0), 1'b1, 1'b0, c1);
    // Negative stride with vl clamp 12 -> 8
    issue(1'b0, 64'h40, 64'hFFFF_FFFF_FFFF_FFF8, 4'd12, '0, 8, 1'b0,
          pk(C | 64'h8, C | 64'h7, C | 64'h6, C | 64'h5, C | 64'h4, C | 64'h3, C | 64'h2, C | 64'h1),
          1'b1, 1'b0, c1);
    // vl=0 load zeroes the result
    issue(1'b0, 64'h100, 64'd8, 4'd0, '0, 0, 1'b0, '0, 1'b1, 1'b0, c1);
    issue(1'b0, 64'h100, 64'd8, 4'd4, '0, 4, 1'b0, ld_a, 1'b1, 1'b0, c1);
    // Misaligned base (load) and misaligned stride (store)
    issue(1'b0, 64'h104, 64'd8, 4'd4, '0, 0, 1'b1, '0, 1'b1, 1'b0, c1);
    issue(1'b1, 64'h200, 64'd12, 4'd2, '1, 0, 1'b1, '0, 1'b1, 1'b0, c1);

    // Busy rejection: request stays asserted with another base during ACCESS
    issue(1'b0, 64'h100, 64'd8, 4'd4, '0, 4, 1'b0, ld_a, 1'b1, 1'b1, c1);
    bus.req_base = 64'h180;
    bus.req_vl   = 4'd1;
    issue(1'b0, 64'h180, 64'd8, 4'd1, '0, 1, 1'b0,
          pk(C | 64'h30, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0), 1'b1, 1'b0, c2);
    chk("busy_accept_cycle", W'(c2), W'(c1 + 6));
    drain();

    // Reset in the middle of a store after two committed words
    issue(1'b1, 64'h300, 64'd8, 4'd6,
          pk(64'h51, 64'h52, 64'h53, 64'h54, 64'h55, 64'h56, 64'd0, 64'd0),
          2, 1'b0, '0, 1'b0, 1'b0, c1);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("pre_abort_write", W'(bus.memwrite_mem), W'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("abort_strobes", W'({bus.memread_mem, bus.memwrite_mem}), '0);
    chk("abort_addr_wd", W'({bus.mem_addr, bus.mem_wd}), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", W'(bus.req_ready), W'(1'b1));
    chk("post_rst_rdata", bus.resp_rdata, '0);
    chk("mem_300", W'(mem[96]), W'(64'h51));
    chk("mem_308", W'(mem[97]), W'(64'h52));
    chk("mem_310", W'(mem[98]), W'(C | 64'h62));
    chk("mem_318", W'(mem[99]), W'(C | 64'h63));
    repeat (5) @(negedge clk);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
